// File: rtl/mms_tx_preempt_sched.sv
// Transmit MAC merge scheduler: shares one byte-wide PHY path between the express
// and preemptable MACs, generating preamble/SMD, mCRC on preemption, and IPG.
module mms_tx_preempt_sched #(
    parameter int MIN_FRAG     = 60,
    parameter int IPG_BYTES    = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic        clk,
    input  logic        reset_begin,
    input  logic        e_valid,
    input  logic [7:0]  e_data,
    input  logic        e_last,
    output logic        e_ready,
    input  logic        p_valid,
    input  logic [7:0]  p_data,
    input  logic        p_last,
    output logic        p_ready,
    input  logic [31:0] p_mcrc,
    input  logic        preempt_en,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        preempted
);

    typedef enum logic [2:0] {IDLE, E_PRE, E_DATA, P_PRE, P_DATA, P_MCRC, IPG} state_t;

    localparam logic [7:0] PRE_FULL   = 8'(PREAMBLE_LEN);
    localparam logic [7:0] PRE_CONT   = 8'(PREAMBLE_LEN - 1);
    // The IDLE decision cycle supplies the last idle byte time of the gap.
    localparam logic [7:0] IPG_LOAD   = 8'(IPG_BYTES - 2);
    localparam logic [8:0] MIN_FRAG_W = 9'(MIN_FRAG);

    function automatic logic [7:0] smd_s_lut(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'hE6;
            2'd1:    return 8'h4C;
            2'd2:    return 8'h7F;
            default: return 8'hB3;
        endcase
    endfunction

    function automatic logic [7:0] smd_c_lut(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h61;
            2'd1:    return 8'h52;
            2'd2:    return 8'h9E;
            default: return 8'h2A;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ipg_cnt_q, ipg_cnt_d;
    logic [7:0]  frag_bytes_q, frag_bytes_d;
    logic [1:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  frag_cnt_q, frag_cnt_d;
    logic        in_pframe_q, in_pframe_d;
    logic [31:0] mcrc_q, mcrc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        preempted_q, preempted_d;
    logic        e_ready_q, p_ready_q;

    logic [7:0]  pre_len;
    logic        e_acc, p_acc, preempt_ok;

    assign pre_len    = in_pframe_q ? PRE_CONT : PRE_FULL;
    assign e_acc      = e_valid & e_ready_q;
    assign p_acc      = p_valid & p_ready_q;
    assign preempt_ok = e_valid & preempt_en & ~p_last
                      & (({1'b0, frag_bytes_q} + 9'd1) >= MIN_FRAG_W);

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        ipg_cnt_d    = ipg_cnt_q;
        frag_bytes_d = frag_bytes_q;
        frame_cnt_d  = frame_cnt_q;
        frag_cnt_d   = frag_cnt_q;
        in_pframe_d  = in_pframe_q;
        mcrc_d       = mcrc_q;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        preempted_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ipg_cnt_q == 8'd0) begin
                    if (e_valid) begin
                        state_d = E_PRE;
                        cnt_d   = 8'd0;
                    end else if (p_valid) begin
                        state_d = P_PRE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            E_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q < PRE_FULL) begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    txd_d   = 8'hD5;
                    state_d = E_DATA;
                end
            end
            E_DATA: begin
                tx_en_d = 1'b1;
                if (e_acc) begin
                    txd_d = e_data;
                    if (e_last) begin
                        state_d   = IPG;
                        ipg_cnt_d = IPG_LOAD;
                    end
                end
            end
            P_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q < pre_len) begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 8'd1;
                end else if (!in_pframe_q) begin
                    txd_d        = preempt_en ? smd_s_lut(frame_cnt_q) : 8'hD5;
                    state_d      = P_DATA;
                    frag_bytes_d = 8'd0;
                end else if (cnt_q == pre_len) begin
                    txd_d = smd_c_lut(frame_cnt_q);
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // frag_cnt already counts this fragment, so the first continuation carries FC0.
                    txd_d        = smd_s_lut(frag_cnt_q - 2'd1);
                    state_d      = P_DATA;
                    frag_bytes_d = 8'd0;
                end
            end
            P_DATA: begin
                tx_en_d = 1'b1;
                if (p_acc) begin
                    txd_d = p_data;
                    if (frag_bytes_q != 8'hFF) begin
                        frag_bytes_d = frag_bytes_q + 8'd1;
                    end
                    if (p_last) begin
                        state_d     = IPG;
                        ipg_cnt_d   = IPG_LOAD;
                        frame_cnt_d = frame_cnt_q + 2'd1;
                        frag_cnt_d  = 2'd0;
                        in_pframe_d = 1'b0;
                    end else if (preempt_ok) begin
                        state_d = P_MCRC;
                        mcrc_d  = p_mcrc;
                        cnt_d   = 8'd0;
                    end
                end
            end
            P_MCRC: begin
                tx_en_d     = 1'b1;
                preempted_d = (cnt_q == 8'd0);
                case (cnt_q[1:0])
                    2'd0:    txd_d = mcrc_q[31:24];
                    2'd1:    txd_d = mcrc_q[23:16];
                    2'd2:    txd_d = mcrc_q[15:8];
                    default: txd_d = mcrc_q[7:0];
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    state_d     = IPG;
                    ipg_cnt_d   = IPG_LOAD;
                    frag_cnt_d  = frag_cnt_q + 2'd1;
                    in_pframe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IPG: begin
                if (ipg_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    ipg_cnt_d = ipg_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_begin) begin
        if (reset_begin) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            ipg_cnt_q    <= 8'd0;
            frag_bytes_q <= 8'd0;
            frame_cnt_q  <= 2'd0;
            frag_cnt_q   <= 2'd0;
            in_pframe_q  <= 1'b0;
            mcrc_q       <= 32'd0;
            txd_q        <= 8'h00;
            tx_en_q      <= 1'b0;
            preempted_q  <= 1'b0;
            e_ready_q    <= 1'b0;
            p_ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ipg_cnt_q    <= ipg_cnt_d;
            frag_bytes_q <= frag_bytes_d;
            frame_cnt_q  <= frame_cnt_d;
            frag_cnt_q   <= frag_cnt_d;
            in_pframe_q  <= in_pframe_d;
            mcrc_q       <= mcrc_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            preempted_q  <= preempted_d;
            e_ready_q    <= (state_d == E_DATA);
            p_ready_q    <= (state_d == P_DATA);
        end
    end

    assign txd       = txd_q;
    assign tx_en     = tx_en_q;
    assign preempted = preempted_q;
    assign e_ready   = e_ready_q;
    assign p_ready   = p_ready_q;

endmodule
